maxpool2x2_stream: RTL and testbench

- Streaming 2x2, stride-2 max-pooling stage that sits directly downstream of the relu block.
- Consumes one signed Q8.8 activation per valid cycle in raster order: row-major, left to right, top to bottom.
- Emits one pooled Q8.8 value per 2x2 window.
- Uses a half-width line buffer holding the horizontal pair-maxima of each even row, so no frame storage is needed.

---
 rtl/maxpool2x2_stream.sv | 126 ++++++++++++
 tb/tb_maxpool2x2_stream.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream
// Streaming 2x2 / stride-2 max-pooling of a raster-ordered signed Q8.8
// feature map. The horizontal pair maximum of each even row is parked in
// a half-width line buffer. On the following odd row it is combined with
// that row's pair maximum to give one pooled result per window.
module maxpool2x2_stream #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] din,
  output logic              out_valid,
  output logic [DATA_W-1:0] dout,
  output logic              frame_done
);

  localparam int COL_W    = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int ROW_W    = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int LB_DEPTH = IMG_W / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [COL_W-1:0] COL_ZERO = COL_W'(0);
  localparam logic [ROW_W-1:0] ROW_ZERO = ROW_W'(0);

  // Two's-complement maximum; on a tie the first operand is returned, which
  // equals the second anyway, so the result is always one of the inputs.
  function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    if ($signed(a) >= $signed(b)) begin
      smax = a;
    end else begin
      smax = b;
    end
  endfunction

  logic [COL_W-1:0]  col_r;
  logic [ROW_W-1:0]  row_r;
  logic [DATA_W-1:0] pair_r;
  logic [DATA_W-1:0] linebuf_r [LB_DEPTH];

  logic              last_col_s;
  logic              last_row_s;
  logic              odd_col_s;
  logic              odd_row_s;
  logic [LB_AW-1:0]  lb_addr_s;
  logic [DATA_W-1:0] lb_rd_s;
  logic [DATA_W-1:0] hmax_s;
  logic [DATA_W-1:0] pool_s;
  logic              lb_we_s;
  logic              fire_s;
  logic              frame_end_s;

  // Decode the raster position and form the pair/window maxima.
  always_comb begin
    last_col_s  = (col_r == COL_LAST);
    last_row_s  = (row_r == ROW_LAST);
    odd_col_s   = col_r[0];
    odd_row_s   = row_r[0];
    lb_addr_s   = LB_AW'(col_r >> 1);
    lb_rd_s     = linebuf_r[lb_addr_s];
    hmax_s      = smax(pair_r, din);
    pool_s      = smax(lb_rd_s, hmax_s);
    lb_we_s     = in_valid & odd_col_s & ~odd_row_s;
    fire_s      = in_valid & odd_col_s & odd_row_s;
    frame_end_s = fire_s & last_col_s & last_row_s;
  end

  // Column/row counters advance only on accepted pixels and wrap per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_r <= COL_ZERO;
      row_r <= ROW_ZERO;
    end else if (in_valid) begin
      if (last_col_s) begin
        col_r <= COL_ZERO;
        if (last_row_s) begin
          row_r <= ROW_ZERO;
        end else begin
          row_r <= row_r + ROW_ONE;
        end
      end else begin
        col_r <= col_r + COL_ONE;
      end
    end
  end

  // Hold the left pixel of each horizontal pair until its partner arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_r <= {DATA_W{1'b0}};
    end else if (in_valid && !odd_col_s) begin
      pair_r <= din;
    end
  end

  // Line buffer: every entry is written on an even row before the odd row
  // reads it, so its contents need no reset.
  always_ff @(posedge clk) begin
    if (lb_we_s) begin
      linebuf_r[lb_addr_s] <= hmax_s;
    end
  end

  // Registered pooled output with single-cycle valid and end-of-frame pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      dout       <= {DATA_W{1'b0}};
    end else begin
      out_valid  <= fire_s;
      frame_done <= frame_end_s;
      if (fire_s) begin
        dout <= pool_s;
      end
    end
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench for maxpool2x2_stream: a 4x4 instance and a 2x2
// instance, each checked every cycle against a frame-array window model,
// plus literal expected result sequences per scenario.
module tb_maxpool2x2_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4 = 1'b1, iv4 = 1'b0, ov4, fd4;
  logic [15:0] din4 = 16'h0000, dout4;
  logic        rst2 = 1'b1, iv2 = 1'b0, ov2, fd2;
  logic [15:0] din2 = 16'h0000, dout2;

  maxpool2x2_stream #(.DATA_W(16), .IMG_W(4), .IMG_H(4)) u4 (
    .clk(clk), .rst(rst4), .in_valid(iv4), .din(din4),
    .out_valid(ov4), .dout(dout4), .frame_done(fd4));

  maxpool2x2_stream #(.DATA_W(16), .IMG_W(2), .IMG_H(2)) u2 (
    .clk(clk), .rst(rst2), .in_valid(iv2), .din(din2),
    .out_valid(ov2), .dout(dout2), .frame_done(fd2));

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Stores the accepted pixels of the current frame as a picture and, when
  // a pixel completes a 2x2 window, takes the max of its four pixels.
  int          img [2][4][4];
  int          mr [2] = '{0, 0};
  int          mc [2] = '{0, 0};
  bit          ev [2] = '{0, 0};
  bit          efd [2] = '{0, 0};
  logic [15:0] ed [2] = '{16'h0000, 16'h0000};

  function automatic int wof(input int u);
    return (u == 0) ? 4 : 2;
  endfunction

  task automatic model_reset(input int u);
    mr[u] = 0; mc[u] = 0; ev[u] = 0; efd[u] = 0; ed[u] = 16'h0000;
  endtask

  task automatic model_step(input int u, input logic v, input logic [15:0] d);
    int m;
    int r;
    int c;
    ev[u] = 0;
    efd[u] = 0;
    if (v) begin
      r = mr[u];
      c = mc[u];
      img[u][r][c] = int'($signed(d));
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        m = img[u][r-1][c-1];
        if (img[u][r-1][c] > m) m = img[u][r-1][c];
        if (img[u][r][c-1] > m) m = img[u][r][c-1];
        if (img[u][r][c] > m) m = img[u][r][c];
        ev[u] = 1;
        ed[u] = m[15:0];
        efd[u] = (r == wof(u) - 1) && (c == wof(u) - 1);
      end
      if (c == wof(u) - 1) begin
        mc[u] = 0;
        mr[u] = (r == wof(u) - 1) ? 0 : r + 1;
      end else begin
        mc[u] = c + 1;
      end
    end
  endtask

  always @(posedge clk or posedge rst4) begin
    if (rst4) model_reset(0);
    else model_step(0, iv4, din4);
  end

  always @(posedge clk or posedge rst2) begin
    if (rst2) model_reset(1);
    else model_step(1, iv2, din2);
  end

  // ---------------- per-cycle compare + capture ----------------
  logic [15:0] got4[$];
  logic [15:0] got2[$];
  int          fdcnt4 = 0;
  int          fdcnt2 = 0;
  logic [15:0] fd_dout4 = 16'h0000;

  always @(negedge clk) begin
    chk("u4.out_valid", {31'd0, ov4}, {31'd0, ev[0]});
    chk("u4.frame_done", {31'd0, fd4}, {31'd0, efd[0]});
    chk("u4.dout", {16'd0, dout4}, {16'd0, ed[0]});
    chk("u2.out_valid", {31'd0, ov2}, {31'd0, ev[1]});
    chk("u2.frame_done", {31'd0, fd2}, {31'd0, efd[1]});
    chk("u2.dout", {16'd0, dout2}, {16'd0, ed[1]});
    if (ov4) got4.push_back(dout4);
    if (ov2) got2.push_back(dout2);
    if (fd4) begin
      fdcnt4++;
      fd_dout4 = dout4;
    end
    if (fd2) fdcnt2++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic px4(input logic [15:0] d, input int gap);
    @(negedge clk);
    iv4 = 1'b1;
    din4 = d;
    repeat (gap) begin
      @(negedge clk);
      iv4 = 1'b0;
      din4 = 16'($urandom);
    end
  endtask

  task automatic px2(input logic [15:0] d);
    @(negedge clk);
    iv2 = 1'b1;
    din2 = d;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    iv4 = 1'b0;
    iv2 = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_seq4(input string nm, input logic [15:0] e [], input int fd_delta, input int fd_before);
    chk({nm, ".count"}, 32'(got4.size()), 32'(e.size()));
    for (int i = 0; i < e.size(); i++) begin
      if (i < got4.size()) chk($sformatf("%s.out%0d", nm, i), {16'd0, got4[i]}, {16'd0, e[i]});
    end
    chk({nm, ".frame_done_count"}, 32'(fdcnt4 - fd_before), 32'(fd_delta));
  endtask

  logic [15:0] seq_up [] = '{16'd1536, 16'd2048, 16'd3584, 16'd4096};
  logic [15:0] seq_b2b [] = '{16'd1536, 16'd2048, 16'd3584, 16'd4096,
                              16'd4096, 16'd3584, 16'd2048, 16'd1536};

  initial begin
    int fd0;
    // reset state
    repeat (2) @(negedge clk);
    chk("reset.u4.out_valid", {31'd0, ov4}, 32'd0);
    chk("reset.u4.dout", {16'd0, dout4}, 32'd0);
    chk("reset.u4.frame_done", {31'd0, fd4}, 32'd0);
    chk("reset.u2.dout", {16'd0, dout2}, 32'd0);
    rst4 = 1'b0;
    rst2 = 1'b0;

    // scenario 1: sequential 4x4 frame, continuous
    got4.delete();
    fd0 = fdcnt4;
    for (int k = 1; k <= 16; k++) px4(16'(k * 256), 0);
    idle(3);
    expect_seq4("seq", seq_up, 1, fd0);
    chk("seq.frame_done_dout", {16'd0, fd_dout4}, 32'd4096);

    // scenario 2: signed compare and all-zero window on a 2x2 map
    got2.delete();
    px2(-16'sd512); px2(-16'sd256); px2(-16'sd768); px2(-16'sd1024);
    idle(2);
    px2(16'h0000); px2(16'h0000); px2(16'h0000); px2(16'h0000);
    idle(2);
    chk("signed.count", 32'(got2.size()), 32'd2);
    if (got2.size() > 0) chk("signed.dout", {16'd0, got2[0]}, 32'h0000FF00);
    if (got2.size() > 1) chk("zero.dout", {16'd0, got2[1]}, 32'd0);
    chk("2x2.frame_done_count", 32'(fdcnt2), 32'd2);

    // scenario 3: gapped input
    got4.delete();
    fd0 = fdcnt4;
    for (int k = 1; k <= 16; k++) px4(16'(k * 256), int'($urandom_range(0, 3)));
    idle(3);
    expect_seq4("gap", seq_up, 1, fd0);

    // scenario 4: asynchronous reset after 9 pixels, then a clean frame
    for (int k = 1; k <= 9; k++) px4(16'(k * 256), 0);
    @(negedge clk);
    iv4 = 1'b0;
    chk("midrst.pre_dout", {16'd0, dout4}, 32'd2048);
    #2 rst4 = 1'b1;
    #1;
    chk("midrst.out_valid", {31'd0, ov4}, 32'd0);
    chk("midrst.dout", {16'd0, dout4}, 32'd0);
    chk("midrst.frame_done", {31'd0, fd4}, 32'd0);
    @(negedge clk);
    rst4 = 1'b0;
    got4.delete();
    fd0 = fdcnt4;
    for (int k = 1; k <= 16; k++) px4(16'(k * 256), 0);
    idle(3);
    expect_seq4("after_rst", seq_up, 1, fd0);

    // scenario 5: two back-to-back frames
    got4.delete();
    fd0 = fdcnt4;
    for (int k = 1; k <= 16; k++) px4(16'(k * 256), 0);
    for (int k = 1; k <= 16; k++) px4(16'((17 - k) * 256), 0);
    idle(3);
    expect_seq4("b2b", seq_b2b, 2, fd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
